rf_wb_buffer: RTL



---
 rtl/rf_wb_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/rf_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_buffer
// Purpose  : In-order writeback FIFO in front of the single register-file
//            write port. It accepts results over valid/ready and drains one
//            per cycle when the port is free. A two-port bypass returns the
//            youngest pending value for a register.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_buffer #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_WIDTH-1:0]       in_ad,
  input  logic [D_WIDTH-1:0]       in_wd,
  input  logic                     port_busy,
  output logic                     we3,
  output logic [A_WIDTH-1:0]       ad3,
  output logic [D_WIDTH-1:0]       wd3,
  input  logic [A_WIDTH-1:0]       q1_ad,
  input  logic [A_WIDTH-1:0]       q2_ad,
  output logic                     q1_hit,
  output logic                     q2_hit,
  output logic [D_WIDTH-1:0]       q1_wd,
  output logic [D_WIDTH-1:0]       q2_wd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [A_WIDTH-1:0] mem_ad_q [DEPTH];
  logic [D_WIDTH-1:0] mem_wd_q [DEPTH];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic               push_acc;
  logic               push;
  logic               pop;

  // Status and drain outputs come only from registered state and port_busy.
  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CW'(DEPTH));
  assign count    = count_q;
  assign pop      = !empty && !port_busy;
  assign we3      = pop;
  assign ad3      = empty ? '0 : mem_ad_q[rptr_q];
  assign wd3      = empty ? '0 : mem_wd_q[rptr_q];

  // Writes to x0 are accepted by the handshake but never stored.
  assign push_acc = in_valid && in_ready;
  assign push     = push_acc && (in_ad != '0);

  // Next-state pointers and occupancy.
  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and counter state; pending entries are abandoned on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; validity is tracked by the pointers so data is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ad_q[wptr_q] <= in_ad;
      mem_wd_q[wptr_q] <= in_wd;
    end
  end

  // Scan occupied entries oldest to youngest so the youngest match wins.
  function automatic logic [D_WIDTH:0] lookup(input logic [A_WIDTH-1:0] qa);
    logic [D_WIDTH:0] res;
    logic [PW-1:0]    idx;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + PW'(k);
      if ((CW'(k) < count_q) && (qa != '0) && (mem_ad_q[idx] == qa)) begin
        res = {1'b1, mem_wd_q[idx]};
      end
    end
    return res;
  endfunction

  // Two independent bypass lookups.
  always_comb begin
    {q1_hit, q1_wd} = lookup(q1_ad);
    {q2_hit, q2_wd} = lookup(q2_ad);
  end

endmodule
`default_nettype wire
